// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 arithmetic sequencer.
//   - op encodings, FSM state encoding, FP16 special constants
//   - flag bit indices into the 5-bit flags word {invalid, overflow, timeout, zero, negative}
//   - helpers: NaN test and flag assembly from a final result
// Optional feature macro used by the sequencer: FP16_SEQ_NAN_PAYLOAD_EN.
package fp16_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_SPECIAL  = 3'd2,
        ST_LAUNCH   = 3'd3,
        ST_WAIT     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;
    localparam logic [15:0] FP16_PINF = 16'h7C00;
    localparam logic [15:0] FP16_NINF = 16'hFC00;

    localparam int FLAG_INVALID  = 4;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_TIMEOUT  = 2;
    localparam int FLAG_ZERO     = 1;
    localparam int FLAG_NEGATIVE = 0;

    typedef struct packed {
        logic snan;
        logic qnan;
        logic inf;
        logic zero;
        logic subnormal;
        logic normal;
        logic sign;
    } fp16_class_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // zero/negative always come from the final result; a NaN never reports negative.
    function automatic logic [4:0] make_flags(input logic [15:0] r, input logic inv,
                                              input logic ovf, input logic tmo);
        logic [4:0] f;
        f = 5'b0;
        f[FLAG_INVALID]  = inv;
        f[FLAG_OVERFLOW] = ovf;
        f[FLAG_TIMEOUT]  = tmo;
        f[FLAG_ZERO]     = (r[14:0] == 15'd0);
        f[FLAG_NEGATIVE] = r[15] & ~is_nan(r);
        return f;
    endfunction

endpackage

// File: rtl/fp16_arith_sequencer_if.sv
// Bus bundle for fp16_arith_sequencer: request handshake, datapath launch/completion,
// and result handshake, plus the busy indicator.
//   slave  : sequencer side
//   master : decode stage / datapath / consumer side (the environment)
// Handshake rules: a request transfers on a rising edge where in_valid & in_ready are both
// high; a result transfers on a rising edge where out_valid & out_ready are both high.
// out_valid, result and flags hold steady until that transfer. dp_done/dp_result/dp_ovf
// are only looked at while the sequencer is waiting on the datapath.
interface fp16_arith_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        dp_start;
    logic        dp_op;
    logic [15:0] dp_a;
    logic [15:0] dp_b;
    logic        dp_done;
    logic [15:0] dp_result;
    logic        dp_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        busy;

    modport slave (
        input  in_valid, op, a, b, dp_done, dp_result, dp_ovf, out_ready,
        output in_ready, dp_start, dp_op, dp_a, dp_b, out_valid, result, flags, busy
    );

    modport master (
        output in_valid, op, a, b, dp_done, dp_result, dp_ovf, out_ready,
        input  in_ready, dp_start, dp_op, dp_a, dp_b, out_valid, result, flags, busy
    );
endinterface

// File: rtl/fp16_operand_classify.sv
// Combinational IEEE-754 binary16 operand classifier.
//   x         : operand
//   snan/qnan : signalling / quiet NaN (quiet bit is mantissa bit 9)
//   inf, zero : infinities / signed zeros
//   subnormal : exponent 0, nonzero mantissa
//   normal    : any other finite value
//   sign      : sign bit
module fp16_operand_classify (
    input  logic [15:0] x,
    output logic        snan,
    output logic        qnan,
    output logic        inf,
    output logic        zero,
    output logic        subnormal,
    output logic        normal,
    output logic        sign
);
    logic exp_max;
    logic exp_min;
    logic man_zero;

    assign exp_max   = (x[14:10] == 5'h1F);
    assign exp_min   = (x[14:10] == 5'h00);
    assign man_zero  = (x[9:0] == 10'd0);

    assign snan      = exp_max & ~man_zero & ~x[9];
    assign qnan      = exp_max & x[9];
    assign inf       = exp_max & man_zero;
    assign zero      = exp_min & man_zero;
    assign subnormal = exp_min & ~man_zero;
    assign normal    = ~exp_max & ~exp_min;
    assign sign      = x[15];
endmodule

// File: rtl/fp16_arith_sequencer.sv
// Multi-cycle controller in front of the shared FP16 add/multiply datapath.
// Accepts one op per handshake, classifies both operands, resolves NaN/inf/zero cases
// locally, otherwise launches the datapath and waits (with timeout) for completion.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : fp16_arith_sequencer_if.slave (request, datapath, result handshakes, busy)
//   dbg_state  : current FSM state
// Parameters: TIMEOUT_CYCLES (cycles spent in WAIT before abort), CNT_W (counter width).
// Macro FP16_SEQ_NAN_PAYLOAD_EN: when defined, a NaN result propagates the first NaN
// operand (a before b) quieted; otherwise all NaN results are canonical 16'h7E00.
module fp16_arith_sequencer
    import fp16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    fp16_arith_sequencer_if.slave  bus,
    output state_t                 dbg_state
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              op_q;
    logic [15:0]       a_q, b_q;
    logic [15:0]       result_q;
    logic [4:0]        flags_q;
    fp16_class_t       ca, cb;
    logic              is_special;
    logic              timeout_hit;
    logic [15:0]       nan_res;
    logic [15:0]       spec_res;
    logic              spec_inv;

    fp16_operand_classify u_cls_a (
        .x(a_q), .snan(ca.snan), .qnan(ca.qnan), .inf(ca.inf), .zero(ca.zero),
        .subnormal(ca.subnormal), .normal(ca.normal), .sign(ca.sign)
    );
    fp16_operand_classify u_cls_b (
        .x(b_q), .snan(cb.snan), .qnan(cb.qnan), .inf(cb.inf), .zero(cb.zero),
        .subnormal(cb.subnormal), .normal(cb.normal), .sign(cb.sign)
    );

    // Only finite nonzero operands (normal or subnormal) need the real datapath.
    assign is_special  = ~((ca.normal | ca.subnormal) & (cb.normal | cb.subnormal));
    assign timeout_hit = (cnt == CNT_LAST);

    assign bus.dp_op   = op_q;
    assign bus.dp_a    = a_q;
    assign bus.dp_b    = b_q;
    assign bus.result  = result_q;
    assign bus.flags   = flags_q;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = (state == ST_IDLE);
        bus.dp_start  = (state == ST_LAUNCH);
        bus.out_valid = (state == ST_DONE);
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE:     if (bus.in_valid) state_nxt = ST_CLASSIFY;
            ST_CLASSIFY: state_nxt = is_special ? ST_SPECIAL : ST_LAUNCH;
            ST_SPECIAL:  state_nxt = ST_DONE;
            ST_LAUNCH:   state_nxt = ST_WAIT;
            ST_WAIT:     if (bus.dp_done || timeout_hit) state_nxt = ST_DONE;
            ST_DONE:     if (bus.out_ready) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Special-case result. Earlier branches take priority: NaN, then invalid combos,
    // then infinities, then zeros.
    always_comb begin
        nan_res  = FP16_QNAN;
`ifdef FP16_SEQ_NAN_PAYLOAD_EN
        if (is_nan(a_q))      nan_res = a_q | 16'h0200;
        else if (is_nan(b_q)) nan_res = b_q | 16'h0200;
`endif
        spec_res = FP16_QNAN;
        spec_inv = 1'b0;
        if (ca.snan || ca.qnan || cb.snan || cb.qnan) begin
            spec_res = nan_res;
            spec_inv = ca.snan | cb.snan;
        end else if (op_q == OP_ADD) begin
            if (ca.inf && cb.inf && (ca.sign != cb.sign)) begin
                spec_res = FP16_QNAN;
                spec_inv = 1'b1;
            end else if (ca.inf)               spec_res = a_q;
            else if (cb.inf)                   spec_res = b_q;
            else if (ca.zero && cb.zero)       spec_res = {ca.sign & cb.sign, 15'd0};
            else if (ca.zero)                  spec_res = b_q;
            else                               spec_res = a_q;
        end else begin
            if ((ca.inf && cb.zero) || (ca.zero && cb.inf)) begin
                spec_res = FP16_QNAN;
                spec_inv = 1'b1;
            end else if (ca.inf || cb.inf)     spec_res = (ca.sign ^ cb.sign) ? FP16_NINF : FP16_PINF;
            else                               spec_res = {ca.sign ^ cb.sign, 15'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 1'b0;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            result_q <= 16'd0;
            flags_q  <= 5'd0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    op_q <= bus.op;
                    a_q  <= bus.a;
                    b_q  <= bus.b;
                end
                ST_SPECIAL: begin
                    result_q <= spec_res;
                    flags_q  <= make_flags(spec_res, spec_inv, 1'b0, 1'b0);
                end
                ST_LAUNCH: cnt <= '0;
                ST_WAIT: begin
                    // Completion outranks a timeout that expires in the same cycle.
                    if (bus.dp_done) begin
                        result_q <= bus.dp_result;
                        flags_q  <= make_flags(bus.dp_result, 1'b0, bus.dp_ovf, 1'b0);
                    end else if (timeout_hit) begin
                        result_q <= FP16_QNAN;
                        flags_q  <= make_flags(FP16_QNAN, 1'b0, 1'b0, 1'b1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_arith_sequencer.sv
// Directed bench for fp16_arith_sequencer: special-case rules, datapath launch/complete,
// timeout and its tie with dp_done, output back-pressure, and mid-operation reset.
module tb_fp16_arith_sequencer;
    import fp16_pkg::*;

    logic   clk;
    logic   reset;
    state_t dbg_state;
    int     checks;
    int     errors;

    fp16_arith_sequencer_if bus_if ();

    fp16_arith_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus_if.slave), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; returns just after the transfer edge.
    task automatic send(input logic op, input logic [15:0] a, input logic [15:0] b);
        bus_if.in_valid = 1'b1;
        bus_if.op       = op;
        bus_if.a        = a;
        bus_if.b        = b;
        check("in_ready_before_send", 32'(bus_if.in_ready), 32'd1);
        step();
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_dp_start(input string tag);
        int n = 0;
        while (bus_if.dp_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, 32'(bus_if.dp_start), 32'd1);
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (bus_if.out_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, 32'(bus_if.out_valid), 32'd1);
    endtask

    task automatic drain();
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        check("drain_out_valid", 32'(bus_if.out_valid), 32'd0);
    endtask

    // Special-path op: DONE is the third cycle after the transfer cycle, no dp_start.
    task automatic special(input string tag, input logic op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_res,
                           input logic [4:0] exp_flags);
        send(op, a, b);
        check({tag, "_ov_c1"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_start_c1"}, 32'(bus_if.dp_start), 32'd0);
        step();
        check({tag, "_ov_c2"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_start_c2"}, 32'(bus_if.dp_start), 32'd0);
        step();
        check({tag, "_ov_c3"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_result"}, 32'(bus_if.result), 32'(exp_res));
        check({tag, "_flags"}, 32'(bus_if.flags), 32'(exp_flags));
        drain();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        check({tag, "_dp_start"}, 32'(bus_if.dp_start), 32'd0);
        check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_result"}, 32'(bus_if.result), 32'd0);
        check({tag, "_flags"}, 32'(bus_if.flags), 32'd0);
        check({tag, "_dp_a"}, 32'(bus_if.dp_a), 32'd0);
        check({tag, "_dp_b"}, 32'(bus_if.dp_b), 32'd0);
        check({tag, "_dp_op"}, 32'(bus_if.dp_op), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [15:0] hold_res;
        logic [4:0]  hold_flags;
        logic [15:0] nan_a_exp;
        logic [15:0] nan_b_exp;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.op        = 1'b0;
        bus_if.a         = 16'd0;
        bus_if.b         = 16'd0;
        bus_if.dp_done   = 1'b0;
        bus_if.dp_result = 16'd0;
        bus_if.dp_ovf    = 1'b0;
        bus_if.out_ready = 1'b0;
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;
        step();

        // MUL 1.0 * 2.0 through the datapath, completion 3 cycles after dp_start.
        send(OP_MUL, 16'h3C00, 16'h4000);
        check("mul_start_classify", 32'(bus_if.dp_start), 32'd0);
        wait_dp_start("mul_start_seen");
        check("mul_dp_a", 32'(bus_if.dp_a), 32'h3C00);
        check("mul_dp_b", 32'(bus_if.dp_b), 32'h4000);
        check("mul_dp_op", 32'(bus_if.dp_op), 32'd1);
        step();
        check("mul_start_one_pulse", 32'(bus_if.dp_start), 32'd0);
        step();
        step();
        bus_if.dp_done   = 1'b1;
        bus_if.dp_result = 16'h4000;
        check("mul_ov_before_done", 32'(bus_if.out_valid), 32'd0);
        step();
        bus_if.dp_done = 1'b0;
        check("mul_ov_after_done", 32'(bus_if.out_valid), 32'd1);
        check("mul_result", 32'(bus_if.result), 32'h4000);
        check("mul_flags", 32'(bus_if.flags), 32'd0);
        check("mul_dp_a_held", 32'(bus_if.dp_a), 32'h3C00);
        drain();

        // Special cases. flags = {invalid, overflow, timeout, zero, negative}.
        special("add_inf_minf", OP_ADD, 16'h7C00, 16'hFC00, 16'h7E00, 5'b10000);
        special("mul_nzero",    OP_MUL, 16'h8000, 16'h3C00, 16'h8000, 5'b00011);
        special("add_nz_nz",    OP_ADD, 16'h8000, 16'h8000, 16'h8000, 5'b00011);
        special("add_pz_nz",    OP_ADD, 16'h0000, 16'h8000, 16'h0000, 5'b00010);
        special("add_zero_x",   OP_ADD, 16'h0000, 16'hBC00, 16'hBC00, 5'b00001);
        special("add_inf_x",    OP_ADD, 16'h3C00, 16'hFC00, 16'hFC00, 5'b00001);
        special("mul_inf_zero", OP_MUL, 16'h7C00, 16'h0000, 16'h7E00, 5'b10000);
        special("mul_ninf_x",   OP_MUL, 16'hFC00, 16'h3C00, 16'hFC00, 5'b00001);
        special("mul_ninf_neg", OP_MUL, 16'hFC00, 16'hC000, 16'h7C00, 5'b00000);
`ifdef FP16_SEQ_NAN_PAYLOAD_EN
        nan_a_exp = 16'h7F01;
        nan_b_exp = 16'hFE01;
`else
        nan_a_exp = 16'h7E00;
        nan_b_exp = 16'h7E00;
`endif
        special("add_snan_a",   OP_ADD, 16'h7D01, 16'h3C00, nan_a_exp, 5'b10000);
        special("mul_qnan_b",   OP_MUL, 16'h3C00, 16'hFE01, nan_b_exp, 5'b00000);

        // Subnormal operand goes to the datapath; overflow reported from it.
        send(OP_MUL, 16'h0001, 16'h3C00);
        wait_dp_start("sub_start_seen");
        step();
        bus_if.dp_done   = 1'b1;
        bus_if.dp_result = 16'h7C00;
        bus_if.dp_ovf    = 1'b1;
        step();
        bus_if.dp_done = 1'b0;
        bus_if.dp_ovf  = 1'b0;
        check("sub_ov", 32'(bus_if.out_valid), 32'd1);
        check("sub_result", 32'(bus_if.result), 32'h7C00);
        check("sub_flags", 32'(bus_if.flags), 32'b01000);
        drain();

        // Timeout: 16 cycles in WAIT, then canonical NaN with timeout flag.
        send(OP_ADD, 16'h3C00, 16'h3C00);
        wait_dp_start("to_start_seen");
        for (int i = 0; i < 16; i++) step();
        check("to_ov_last_wait", 32'(bus_if.out_valid), 32'd0);
        check("to_state_last_wait", 32'(dbg_state), 32'(ST_WAIT));
        step();
        check("to_ov", 32'(bus_if.out_valid), 32'd1);
        check("to_result", 32'(bus_if.result), 32'h7E00);
        check("to_flags", 32'(bus_if.flags), 32'b00100);
        drain();
        bus_if.dp_done   = 1'b1;
        bus_if.dp_result = 16'h1234;
        step();
        bus_if.dp_done = 1'b0;
        check("late_done_busy", 32'(bus_if.busy), 32'd0);
        check("late_done_ov", 32'(bus_if.out_valid), 32'd0);
        check("late_done_result", 32'(bus_if.result), 32'h7E00);

        // dp_done in the final WAIT cycle wins over timeout.
        send(OP_ADD, 16'h3C00, 16'h3C00);
        wait_dp_start("tie_start_seen");
        for (int i = 0; i < 16; i++) step();
        bus_if.dp_done   = 1'b1;
        bus_if.dp_result = 16'h4000;
        step();
        bus_if.dp_done = 1'b0;
        check("tie_ov", 32'(bus_if.out_valid), 32'd1);
        check("tie_result", 32'(bus_if.result), 32'h4000);
        check("tie_flags", 32'(bus_if.flags), 32'd0);
        drain();

        // Back-pressure: result/flags stable for 5 cycles with out_ready low.
        send(OP_MUL, 16'h8000, 16'h3C00);
        wait_out("bp_ov");
        hold_res   = bus_if.result;
        hold_flags = bus_if.flags;
        check("bp_first_result", 32'(hold_res), 32'h8000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_ov_held", 32'(bus_if.out_valid), 32'd1);
            check("bp_result_held", 32'(bus_if.result), 32'(hold_res));
            check("bp_flags_held", 32'(bus_if.flags), 32'(hold_flags));
            check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
        end
        // A request waiting during the accept cycle is not taken in that cycle.
        bus_if.in_valid  = 1'b1;
        bus_if.op        = OP_ADD;
        bus_if.a         = 16'h4000;
        bus_if.b         = 16'h4000;
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b0;
        check("bp_no_same_cycle_accept", 32'(bus_if.busy), 32'd0);
        check("bp_dp_a_unchanged", 32'(bus_if.dp_a), 32'h8000);

        // Reset while waiting on the datapath.
        send(OP_ADD, 16'h3C00, 16'h4000);
        wait_dp_start("rst_start_seen");
        step();
        check("rst_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b1;
        step();
        check_reset_values("mid_reset");
        reset = 1'b0;
        bus_if.dp_done   = 1'b1;
        bus_if.dp_result = 16'h4200;
        step();
        bus_if.dp_done = 1'b0;
        check("post_reset_done_busy", 32'(bus_if.busy), 32'd0);
        check("post_reset_done_ov", 32'(bus_if.out_valid), 32'd0);
        check("post_reset_done_result", 32'(bus_if.result), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
